// File: rtl/matmul_stream_core.sv
// Streaming O = W x X engine: operands arrive row-major over a valid/ready input, results leave
// row-major over a valid/ready output with row/col tags, one MAC per cycle in between.
module matmul_stream_core #(
    parameter int unsigned DW   = 4,
    parameter int unsigned MAXD = 3,
    parameter int unsigned DIMW = $clog2(MAXD + 1),
    parameter int unsigned ACCW = 2 * DW + $clog2(MAXD)
) (
    input  logic            clk,
    input  logic            clear_mem,
    input  logic            start,
    input  logic [DIMW-1:0] row_w,
    input  logic [DIMW-1:0] col_w,
    input  logic [DIMW-1:0] row_x,
    input  logic [DIMW-1:0] col_x,
    input  logic            in_valid,
    input  logic [DW-1:0]   in_data,
    output logic            in_ready,
    output logic            out_valid,
    output logic [ACCW-1:0] out_data,
    output logic [DIMW-1:0] out_row,
    output logic [DIMW-1:0] out_col,
    output logic            out_last,
    input  logic            out_ready,
    output logic            busy,
    output logic            done,
    output logic            dim_err
);

    typedef enum logic [2:0] {StIdle, StLoadW, StLoadX, StMac, StOut} state_e;

    state_e          state;
    logic [DW-1:0]   w_mem [MAXD][MAXD];
    logic [DW-1:0]   x_mem [MAXD][MAXD];
    logic [DIMW-1:0] dim_m, dim_k, dim_n;
    logic [DIMW-1:0] r, c, i, j, k;
    logic [ACCW-1:0] acc;

    logic [DIMW-1:0] m_last, k_last, n_last;
    logic [ACCW-1:0] prod, acc_next;
    logic            dims_bad;
    logic            beat;

    always_comb begin
        m_last   = dim_m - DIMW'(1);
        k_last   = dim_k - DIMW'(1);
        n_last   = dim_n - DIMW'(1);
        dims_bad = (row_w == '0) || (col_w == '0) || (row_x == '0) || (col_x == '0) ||
                   (row_w > DIMW'(MAXD)) || (col_w > DIMW'(MAXD)) ||
                   (row_x > DIMW'(MAXD)) || (col_x > DIMW'(MAXD)) || (col_w != row_x);
        prod     = ACCW'(w_mem[i][k]) * ACCW'(x_mem[k][j]);
        // First k of each element restarts the sum instead of adding to the old result
        acc_next = ((k == '0) ? '0 : acc) + prod;
        in_ready = (state == StLoadW) || (state == StLoadX);
        busy     = (state != StIdle);
        beat     = in_valid && in_ready;
    end

    always_ff @(posedge clk) begin
        if (clear_mem) begin
            state     <= StIdle;
            dim_m     <= '0;
            dim_k     <= '0;
            dim_n     <= '0;
            r         <= '0;
            c         <= '0;
            i         <= '0;
            j         <= '0;
            k         <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_row   <= '0;
            out_col   <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
            dim_err   <= 1'b0;
            for (int unsigned a = 0; a < MAXD; a++) begin
                for (int unsigned b = 0; b < MAXD; b++) begin
                    w_mem[a][b] <= '0;
                    x_mem[a][b] <= '0;
                end
            end
        end else begin
            done    <= 1'b0;
            dim_err <= 1'b0;
            case (state)
                StIdle: begin
                    if (start) begin
                        if (dims_bad) begin
                            dim_err <= 1'b1;
                        end else begin
                            dim_m <= row_w;
                            dim_k <= col_w;
                            dim_n <= col_x;
                            r     <= '0;
                            c     <= '0;
                            state <= StLoadW;
                        end
                    end
                end
                StLoadW: begin
                    if (beat) begin
                        w_mem[r][c] <= in_data;
                        if (c == k_last) begin
                            c <= '0;
                            if (r == m_last) begin
                                r     <= '0;
                                state <= StLoadX;
                            end else begin
                                r <= r + DIMW'(1);
                            end
                        end else begin
                            c <= c + DIMW'(1);
                        end
                    end
                end
                StLoadX: begin
                    if (beat) begin
                        x_mem[r][c] <= in_data;
                        if (c == n_last) begin
                            c <= '0;
                            if (r == k_last) begin
                                r     <= '0;
                                i     <= '0;
                                j     <= '0;
                                k     <= '0;
                                state <= StMac;
                            end else begin
                                r <= r + DIMW'(1);
                            end
                        end else begin
                            c <= c + DIMW'(1);
                        end
                    end
                end
                StMac: begin
                    acc <= acc_next;
                    if (k == k_last) begin
                        k         <= '0;
                        out_valid <= 1'b1;
                        out_data  <= acc_next;
                        out_row   <= i;
                        out_col   <= j;
                        out_last  <= (i == m_last) && (j == n_last);
                        state     <= StOut;
                    end else begin
                        k <= k + DIMW'(1);
                    end
                end
                StOut: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (out_last) begin
                            done  <= 1'b1;
                            state <= StIdle;
                        end else begin
                            if (j == n_last) begin
                                j <= '0;
                                i <= i + DIMW'(1);
                            end else begin
                                j <= j + DIMW'(1);
                            end
                            state <= StMac;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_stream_core.sv
// Directed bench for matmul_stream_core: jobs push expected elements into a queue, a negedge
// monitor pops and checks every output handshake and the hold-stability under backpressure.
module tb_matmul_stream_core;

    localparam int unsigned DW   = 4;
    localparam int unsigned MAXD = 3;
    localparam int unsigned DIMW = 2;
    localparam int unsigned ACCW = 10;

    logic            clk = 1'b0;
    logic            clear_mem = 1'b1;
    logic            start = 1'b0;
    logic [DIMW-1:0] row_w = '0, col_w = '0, row_x = '0, col_x = '0;
    logic            in_valid = 1'b0;
    logic [DW-1:0]   in_data = '0;
    logic            in_ready;
    logic            out_valid;
    logic [ACCW-1:0] out_data;
    logic [DIMW-1:0] out_row, out_col;
    logic            out_last;
    logic            out_ready = 1'b1;
    logic            busy, done, dim_err;

    matmul_stream_core #(.DW(DW), .MAXD(MAXD)) dut (
        .clk(clk), .clear_mem(clear_mem), .start(start),
        .row_w(row_w), .col_w(col_w), .row_x(row_x), .col_x(col_x),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_row(out_row), .out_col(out_col),
        .out_last(out_last), .out_ready(out_ready),
        .busy(busy), .done(done), .dim_err(dim_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int row;
        int col;
        int data;
        bit last;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   bp_mode = 1'b0;
    int   bp_cnt = 0;
    int   wv[9], xv[9], ev[9];

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Consumer: always ready, or ready one cycle in three
    initial forever begin
        @(posedge clk);
        #1;
        bp_cnt++;
        out_ready = bp_mode ? (bp_cnt % 3 == 0) : 1'b1;
    end

    exp_t e;
    bit   hold_pend = 1'b0;
    int   hold_data, hold_row, hold_col;
    bit   hold_last;

    always @(negedge clk) begin
        if (hold_pend) begin
            check("hold_valid", int'(out_valid), 1);
            check("hold_data", int'(out_data), hold_data);
            check("hold_tag", int'(out_row) * 4 + int'(out_col), hold_row * 4 + hold_col);
            check("hold_last", int'(out_last), int'(hold_last));
        end
        hold_pend = 1'b0;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", int'(out_data), -1);
            end else begin
                e = exp_q.pop_front();
                check("out_data", int'(out_data), e.data);
                check("out_row", int'(out_row), e.row);
                check("out_col", int'(out_col), e.col);
                check("out_last", int'(out_last), int'(e.last));
            end
        end else if (out_valid) begin
            hold_pend = 1'b1;
            hold_data = int'(out_data);
            hold_row  = int'(out_row);
            hold_col  = int'(out_col);
            hold_last = out_last;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int m, input int kw, input int kx, input int n);
        row_w = DIMW'(m);
        col_w = DIMW'(kw);
        row_x = DIMW'(kx);
        col_x = DIMW'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_beat(input int d, input bit gap, output bit ok);
        int t;
        if (gap) begin
            in_valid = 1'b0;
            tick();
        end
        in_valid = 1'b1;
        in_data  = DW'(d);
        ok = 1'b0;
        t = 0;
        while (!ok && t < 50) begin
            @(negedge clk);
            ok = in_ready;
            tick();
            t++;
        end
        if (!ok) check("in_ready_timeout", 0, 1);
    endtask

    // Runs an m x k by k x n job from wv/xv; abort_after > 0 aborts via clear_mem after that many
    // W beats, mid_start pulses start with other dims during the first MAC cycle.
    task automatic run_job(input int m, input int kk, input int n, input bit gap,
                           input bit mid_start, input int abort_after);
        bit ok;
        bit seen;
        exp_t x;
        if (abort_after == 0) begin
            for (int a = 0; a < m; a++) begin
                for (int b = 0; b < n; b++) begin
                    x.row  = a;
                    x.col  = b;
                    x.data = ev[a * n + b];
                    x.last = (a == m - 1) && (b == n - 1);
                    exp_q.push_back(x);
                end
            end
        end
        pulse_start(m, kk, kk, n);
        check("busy_after_start", int'(busy), 1);
        for (int b = 0; b < m * kk; b++) begin
            send_beat(wv[b], gap && (b % 2 == 1), ok);
            if (abort_after != 0 && b + 1 == abort_after) begin
                in_valid  = 1'b0;
                clear_mem = 1'b1;
                tick();
                clear_mem = 1'b0;
                check("abort_outs", int'({out_valid, out_data, out_row, out_col, out_last}), 0);
                check("abort_flags", int'({busy, in_ready, done, dim_err}), 0);
                return;
            end
        end
        for (int b = 0; b < kk * n; b++) send_beat(xv[b], gap && (b % 2 == 1), ok);
        in_valid = 1'b0;
        check("in_ready_after_load", int'(in_ready), 0);
        if (mid_start) pulse_start(2, 2, 2, 2);
        seen = 1'b0;
        for (int t = 0; t < 400 && !seen; t++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("done_pulse", int'(seen), 1);
        tick();
        check("done_one_cycle", int'(done), 0);
        check("idle_after_job", int'(busy), 0);
        check("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        tick();
        tick();
        clear_mem = 1'b0;
        check("reset_outs", int'({out_valid, out_data, out_row, out_col, out_last}), 0);
        check("reset_flags", int'({busy, in_ready, done, dim_err}), 0);

        // 1: 3x2 by 2x3
        wv = '{1, 3, 4, 5, 6, 7, 0, 0, 0};
        xv = '{8, 9, 10, 11, 12, 13, 0, 0, 0};
        ev = '{41, 45, 49, 87, 96, 105, 125, 138, 151};
        run_job(3, 2, 3, 1'b0, 1'b0, 0);

        // 2: 3x3 all 15 -> 3*225
        wv = '{15, 15, 15, 15, 15, 15, 15, 15, 15};
        xv = '{15, 15, 15, 15, 15, 15, 15, 15, 15};
        ev = '{675, 675, 675, 675, 675, 675, 675, 675, 675};
        run_job(3, 3, 3, 1'b0, 1'b0, 0);

        // 3: illegal dims
        pulse_start(2, 2, 3, 2);
        check("dim_err_mismatch", int'(dim_err), 1);
        check("busy_mismatch", int'(busy), 0);
        check("in_ready_mismatch", int'(in_ready), 0);
        tick();
        check("dim_err_one_cycle", int'(dim_err), 0);
        pulse_start(0, 2, 2, 2);
        check("dim_err_zero", int'(dim_err), 1);
        check("busy_zero", int'(busy), 0);
        tick();
        check("dim_err_zero_clr", int'(dim_err), 0);

        // 4: test 1 with gapped input and 1-in-3 consumer
        wv = '{1, 3, 4, 5, 6, 7, 0, 0, 0};
        xv = '{8, 9, 10, 11, 12, 13, 0, 0, 0};
        ev = '{41, 45, 49, 87, 96, 105, 125, 138, 151};
        bp_mode = 1'b1;
        run_job(3, 2, 3, 1'b1, 1'b0, 0);
        bp_mode = 1'b0;
        tick();

        // 5: abort after 4 W beats, then a fresh 2x2 job
        run_job(3, 2, 3, 1'b0, 1'b0, 4);
        repeat (5) tick();
        check("no_out_after_abort", exp_q.size(), 0);
        wv = '{1, 2, 3, 4, 0, 0, 0, 0, 0};
        xv = '{5, 6, 7, 8, 0, 0, 0, 0, 0};
        ev = '{19, 22, 43, 50, 0, 0, 0, 0, 0};
        run_job(2, 2, 2, 1'b0, 1'b0, 0);

        // 6: start pulsed during MAC is ignored
        wv = '{1, 3, 4, 5, 6, 7, 0, 0, 0};
        xv = '{8, 9, 10, 11, 12, 13, 0, 0, 0};
        ev = '{41, 45, 49, 87, 96, 105, 125, 138, 151};
        run_job(3, 2, 3, 1'b0, 1'b1, 0);
        repeat (3) tick();
        check("final_idle", int'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end

endmodule
